// File: rtl/ltpi_nl_gpio_tx_chunker_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ltpi_nl_gpio_tx_chunker_if
//  Purpose  : Frame-builder side handshake bundle of the NL GPIO TX chunker.
//             master = chunker (drives payload), slave = frame builder.
//  Signals  : frame_req     request for the next payload (one-cycle pulse)
//             frame_valid   frame_data / frame_index valid
//             frame_ready   frame builder accepts the payload
//             frame_data    CHUNK_W-bit chunk payload
//             frame_index   chunk number within the round
//             snapshot_done pulse when the last chunk of a round is accepted
//  Revision : 1.0  initial release
// ============================================================================
interface ltpi_nl_gpio_tx_chunker_if #(
    parameter int CHUNK_W = 16,
    parameter int IDX_W   = 6
);
    logic               frame_req;
    logic               frame_valid;
    logic               frame_ready;
    logic [CHUNK_W-1:0] frame_data;
    logic [IDX_W-1:0]   frame_index;
    logic               snapshot_done;

    modport master (
        input  frame_req,
        input  frame_ready,
        output frame_valid,
        output frame_data,
        output frame_index,
        output snapshot_done
    );

    modport slave (
        output frame_req,
        output frame_ready,
        input  frame_valid,
        input  frame_data,
        input  frame_index,
        input  snapshot_done
    );
endinterface
`default_nettype wire

// File: rtl/ltpi_nl_gpio_tx_chunker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ltpi_nl_gpio_tx_chunker
//  Purpose  : Snapshots the NL GPIO vector once per round and offers it to the
//             LTPI frame builder one CHUNK_W-bit chunk per frame, with a frame
//             index locating the chunk on the remote side.
//  Ports    : clk, reset (sync, active high), link_up (low forces idle),
//             nl_gpio_in (live NL GPIO inputs),
//             bus (master modport: frame_req/frame_ready in,
//                  frame_valid/frame_data/frame_index/snapshot_done out)
//  Options  : LTPI_NL_GPIO_SYNC_EN - insert a 2-flop synchronizer on
//             nl_gpio_in ahead of the snapshot register.
//  Revision : 1.0  initial release
// ============================================================================
module ltpi_nl_gpio_tx_chunker #(
    parameter int NL_GPIO_WIDTH = 1024,
    parameter int CHUNK_W       = 16
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     link_up,
    input  wire logic [NL_GPIO_WIDTH-1:0] nl_gpio_in,
    ltpi_nl_gpio_tx_chunker_if.master     bus
);
    localparam int N_CHUNKS = NL_GPIO_WIDTH / CHUNK_W;
    localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_CHUNKS - 1);

    generate
        if ((NL_GPIO_WIDTH % CHUNK_W) != 0) begin : g_width_check
            $error("NL_GPIO_WIDTH must be an exact multiple of CHUNK_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_OFFER = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Snapshot held as an array of chunks so the index selects directly.
    logic [N_CHUNKS-1:0][CHUNK_W-1:0] r_snap;
    logic [NL_GPIO_WIDTH-1:0]         w_src;
    logic [CHUNK_W-1:0]               r_data;
    logic [IDX_W-1:0]                 r_index;
    logic                             r_valid;
    logic                             r_done;

`ifdef LTPI_NL_GPIO_SYNC_EN
    logic [NL_GPIO_WIDTH-1:0] r_sync1;
    logic [NL_GPIO_WIDTH-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= nl_gpio_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = nl_gpio_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Link loss overrides every handshake transition.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (link_up)         w_next_state = S_ARM;
            S_ARM:   if (bus.frame_req)   w_next_state = S_OFFER;
            S_OFFER: if (bus.frame_ready) w_next_state = S_ARM;
            default:                      w_next_state = S_IDLE;
        endcase
        if (!link_up) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap  <= '0;
            r_data  <= '0;
            r_index <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!link_up) begin
                // Pending payload is dropped without advancing the index.
                r_valid <= 1'b0;
                r_index <= '0;
            end else begin
                case (r_state)
                    S_ARM: begin
                        if (bus.frame_req) begin
                            r_valid <= 1'b1;
                            if (r_index == '0) begin
                                // Round start: one coherent capture for all chunks.
                                r_snap <= w_src;
                                r_data <= w_src[CHUNK_W-1:0];
                            end else begin
                                r_data <= r_snap[r_index];
                            end
                        end
                    end
                    S_OFFER: begin
                        if (bus.frame_ready) begin
                            r_valid <= 1'b0;
                            if (r_index == c_last_idx) begin
                                r_index <= '0;
                                r_done  <= 1'b1;
                            end else begin
                                r_index <= r_index + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_valid <= 1'b0;
                        r_index <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.frame_valid   = r_valid;
    assign bus.frame_data    = r_data;
    assign bus.frame_index   = r_index;
    assign bus.snapshot_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ltpi_nl_gpio_tx_chunker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ltpi_nl_gpio_tx_chunker
//  Purpose  : Self-checking bench for ltpi_nl_gpio_tx_chunker with 64-bit
//             NL GPIO vector and 16-bit chunks (4 chunks per round).
//             Honours LTPI_NL_GPIO_SYNC_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ltpi_nl_gpio_tx_chunker;
    localparam int c_w      = 64;
    localparam int c_chunk  = 16;
    localparam int c_n      = 4;
    localparam int c_idx_w  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           link_up;
    logic [c_w-1:0] nl_gpio_in;

    int checks = 0;
    int errors = 0;

    // Reference model: snapshot of the current round and the chunk cursor.
    logic [c_w-1:0] m_snap;
    int             m_idx;
    // Input seen one and two cycles ago (after a 2-flop synchronizer view).
    logic [c_w-1:0] hist0, hist1;

    ltpi_nl_gpio_tx_chunker_if #(.CHUNK_W(c_chunk), .IDX_W(c_idx_w)) u_if ();

    ltpi_nl_gpio_tx_chunker #(
        .NL_GPIO_WIDTH(c_w),
        .CHUNK_W      (c_chunk)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .link_up   (link_up),
        .nl_gpio_in(nl_gpio_in),
        .bus       (u_if.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] chunk_of(input logic [63:0] v, input int k);
        return v[k*16 +: 16];
    endfunction

    task automatic tick();
        if (reset) begin
            hist0 = '0;
            hist1 = '0;
        end else begin
            hist1 = hist0;
            hist0 = nl_gpio_in;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_tick(input string tag);
        tick();
        chk({tag, "_valid"}, 64'(u_if.frame_valid), 64'd0);
    endtask

    task automatic request(input string tag);
        logic [63:0] cap;
`ifdef LTPI_NL_GPIO_SYNC_EN
        cap = hist1;
`else
        cap = nl_gpio_in;
`endif
        u_if.frame_req = 1'b1;
        tick();
        u_if.frame_req = 1'b0;
        if (m_idx == 0) m_snap = cap;
        chk({tag, "_valid"}, 64'(u_if.frame_valid), 64'd1);
        chk({tag, "_data"},  64'(u_if.frame_data),  64'(chunk_of(m_snap, m_idx)));
        chk({tag, "_index"}, 64'(u_if.frame_index), 64'(m_idx));
    endtask

    task automatic accept(input string tag);
        logic wrap;
        u_if.frame_ready = 1'b1;
        tick();
        u_if.frame_ready = 1'b0;
        wrap  = (m_idx == c_n - 1);
        m_idx = (m_idx + 1) % c_n;
        chk({tag, "_acc_valid"}, 64'(u_if.frame_valid),   64'd0);
        chk({tag, "_acc_index"}, 64'(u_if.frame_index),   64'(m_idx));
        chk({tag, "_acc_done"},  64'(u_if.snapshot_done), 64'(wrap));
    endtask

    // Stall with ready low for n cycles, pulsing frame_req at cycle pulse_at.
    task automatic hold(input string tag, input int n, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            u_if.frame_ready = 1'b0;
            u_if.frame_req   = (i == pulse_at);
            tick();
            u_if.frame_req   = 1'b0;
            chk({tag, "_hold_valid"}, 64'(u_if.frame_valid), 64'd1);
            chk({tag, "_hold_data"},  64'(u_if.frame_data),  64'(chunk_of(m_snap, m_idx)));
            chk({tag, "_hold_index"}, 64'(u_if.frame_index), 64'(m_idx));
        end
    endtask

    task automatic finish_round(input string tag);
        accept(tag);
        while (m_idx != 0) begin
            request(tag);
            accept(tag);
        end
    endtask

    initial begin
        logic [15:0] exp_rt [4];
        logic [63:0] v;
        exp_rt = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
        m_snap = '0;
        m_idx  = 0;
        hist0  = '0;
        hist1  = '0;

        // Reset with random activity on the inputs.
        reset            = 1'b1;
        link_up          = 1'b1;
        u_if.frame_req   = 1'b0;
        u_if.frame_ready = 1'b0;
        nl_gpio_in       = '0;
        for (int i = 0; i < 3; i++) begin
            nl_gpio_in       = {$urandom, $urandom};
            u_if.frame_req   = 1'($urandom_range(0, 1));
            u_if.frame_ready = 1'($urandom_range(0, 1));
            tick();
            chk("rst_valid", 64'(u_if.frame_valid),   64'd0);
            chk("rst_data",  64'(u_if.frame_data),    64'd0);
            chk("rst_index", 64'(u_if.frame_index),   64'd0);
            chk("rst_done",  64'(u_if.snapshot_done), 64'd0);
        end
        reset            = 1'b0;
        u_if.frame_req   = 1'b0;
        u_if.frame_ready = 1'b0;
        for (int i = 0; i < 3; i++) idle_tick("noreq");

        // Round trip with the reference vector.
        nl_gpio_in = 64'h0123_4567_89AB_CDEF;
        tick();
        tick();
        for (int k = 0; k < c_n; k++) begin
            request("rt");
            chk("rt_lit", 64'(u_if.frame_data), 64'(exp_rt[k]));
            accept("rt");
        end
        tick();
        chk("rt_done_once", 64'(u_if.snapshot_done), 64'd0);
        chk("rt_idx_zero",  64'(u_if.frame_index),   64'd0);

        // Coherency: input change after chunk 0 only shows next round.
        request("coh");
        accept("coh");
        nl_gpio_in = '1;
        for (int k = 1; k < c_n; k++) begin
            request("coh");
            chk("coh_lit", 64'(u_if.frame_data), 64'(exp_rt[k]));
            accept("coh");
        end
        for (int k = 0; k < c_n; k++) begin
            request("coh2");
            chk("coh2_lit", 64'(u_if.frame_data), 64'hFFFF);
            accept("coh2");
        end

        // Backpressure, then link drop with index 2 valid.
        nl_gpio_in = {$urandom, $urandom};
        tick();
        tick();
        request("bp");
        hold("bp", 5, 2);
        accept("bp");
        idle_tick("bp_nosecond");
        request("ld");
        accept("ld");
        request("ld");
        chk("ld_pre_idx", 64'(u_if.frame_index), 64'd2);
        link_up = 1'b0;
        tick();
        m_idx = 0;
        chk("ld_valid", 64'(u_if.frame_valid),   64'd0);
        chk("ld_index", 64'(u_if.frame_index),   64'd0);
        chk("ld_done",  64'(u_if.snapshot_done), 64'd0);
        v          = {$urandom, $urandom};
        nl_gpio_in = v;
        link_up    = 1'b1;
        idle_tick("ld_rearm");
        idle_tick("ld_wait");
        request("ld_fresh");
        chk("ld_fresh_lit", 64'(u_if.frame_data), 64'(v[15:0]));
        finish_round("ld_fresh");

        // Input-to-capture latency.
`ifdef LTPI_NL_GPIO_SYNC_EN
        nl_gpio_in = 64'h1111_2222_3333_4444;
        tick();
        tick();
        tick();
        nl_gpio_in = 64'h5555_6666_7777_8888;
        tick();
        request("sync_old");
        chk("sync_old_lit", 64'(u_if.frame_data), 64'h4444);
        finish_round("sync_old");
        nl_gpio_in = 64'h9999_AAAA_BBBB_CCCC;
        tick();
        tick();
        request("sync_new");
        chk("sync_new_lit", 64'(u_if.frame_data), 64'hCCCC);
        finish_round("sync_new");
`else
        nl_gpio_in = 64'h5555_6666_7777_8888;
        request("nosync");
        chk("nosync_lit", 64'(u_if.frame_data), 64'h8888);
        finish_round("nosync");
`endif

        // Randomized rounds: stalls, gaps and mid-round input churn.
        for (int r = 0; r < 8; r++) begin
            nl_gpio_in = {$urandom, $urandom};
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_tick("rnd_gap");
            for (int k = 0; k < c_n; k++) begin
                request("rnd");
                if ($urandom_range(0, 1) == 1) nl_gpio_in = {$urandom, $urandom};
                hold("rnd", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                accept("rnd");
                if ($urandom_range(0, 1) == 1) idle_tick("rnd_gap2");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
